t03_mem_request_arbiter: RTL and testbench

Parametrised successor to the team's cached request unit. It arbitrates the single memory bus between instruction-cache refills and data loads/stores. Unlike the previous unit, it latches address, write data and byte enables at issue, so bus outputs stay stable for the whole transaction. It also aborts stalled transactions with a watchdog timeout and raises a one-cycle cache-fill strobe. It sits between the CPU datapath/control, the instruction cache and the wishbone-style memory manager.

---
 rtl/t03_req_pkg.sv | 15 +
 rtl/t03_req_watchdog.sv | 33 +++
 rtl/t03_mem_request_arbiter.sv | 131 +++++++++++++
 tb/tb_t03_mem_request_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/t03_req_pkg.sv
// Shared types and constants for the memory request arbiter.
package t03_req_pkg;

  // Bus ownership states: IDLE, instruction refill, data load, data store.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FETCH  = 2'b01,
    DREAD  = 2'b10,
    DWRITE = 2'b11
  } state_t;

  // Default watchdog limit, in cycles waited for ack.
  localparam int DEFAULT_TIMEOUT = 256;

endpackage

// File: rtl/t03_req_watchdog.sv
// Per-transaction watchdog counter. It restarts on clear, counts cycles
// without ack, and flags expire when the final permitted cycle is reached.
module t03_req_watchdog
  import t03_req_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // Count cycles spent waiting; clear takes priority so each transaction starts at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign expire = (count == LAST);

endmodule

// File: rtl/t03_mem_request_arbiter.sv
// Arbitrates the single memory bus between instruction-cache refills and
// data loads/stores. Bus address, store data and byte enables are captured
// at issue so they stay stable for the whole transaction; a watchdog aborts
// transactions that never see ack.
module t03_mem_request_arbiter
  import t03_req_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ack,
  input  logic                next_hit,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [ADDR_W-1:0]   pc,
  input  logic [ADDR_W-1:0]   alu_addr,
  input  logic [DATA_W-1:0]   wdata_in,
  input  logic [DATA_W/8-1:0] be_in,
  output logic                read,
  output logic                write,
  output logic [ADDR_W-1:0]   address,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] be,
  output logic                freeze_pc,
  output logic                freeze_instr,
  output logic                cache_fill,
  output logic                timeout_pulse,
  output logic                timeout_err,
  output logic                busy
);

  state_t state_q;
  state_t next_state;
  logic   expire;
  logic   data_state;
  logic   issue;
  logic   wd_clear;

  assign data_state = (state_q == DREAD) || (state_q == DWRITE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= next_state;
    end
  end

  // Next-state decision: request priority from IDLE, ack/abort elsewhere.
  always_comb begin
    next_state = state_q;
    if (rst) begin
      next_state = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_read)       next_state = DREAD;
          else if (mem_write) next_state = DWRITE;
          else if (!next_hit) next_state = FETCH;
        end
        FETCH: begin
          if (ack)         next_state = IDLE;
          else if (expire) next_state = IDLE;
        end
        DREAD, DWRITE: begin
          if (ack)         next_state = next_hit ? IDLE : FETCH;
          else if (expire) next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // A new transaction is issued leaving IDLE, or chaining a data access straight into a refill.
  assign issue = ((state_q == IDLE) && (next_state != IDLE)) ||
                 (data_state && (next_state == FETCH));

  // Capture bus address, store data and byte enables at issue; reads drive all-ones data/enables.
  always_ff @(posedge clk) begin
    if (rst) begin
      address <= '0;
      wdata   <= '0;
      be      <= '0;
    end else if (issue) begin
      address <= (next_state == FETCH) ? pc : alu_addr;
      if (next_state == DWRITE) begin
        wdata <= wdata_in;
        be    <= be_in;
      end else begin
        wdata <= '1;
        be    <= '1;
      end
    end
  end

  // Sticky abort flag, set on the edge after the abort strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_err <= 1'b0;
    end else if (timeout_pulse) begin
      timeout_err <= 1'b1;
    end
  end

  // Restart the watchdog whenever a new state is entered (and keep it idle-cleared).
  assign wd_clear = (state_q == IDLE) || (next_state != state_q);

  t03_req_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .clear (wd_clear),
    .inc   (!ack),
    .expire(expire)
  );

  assign busy          = (state_q != IDLE);
  assign read          = (state_q == FETCH) || (state_q == DREAD);
  assign write         = (state_q == DWRITE);
  assign freeze_instr  = busy;
  assign cache_fill    = !rst && (state_q == FETCH) && ack;
  assign timeout_pulse = !rst && busy && !ack && expire;
  assign freeze_pc     = busy ? !(data_state && ack && (next_state == IDLE))
                              : (next_state != IDLE);

endmodule

// File: tb/tb_t03_mem_request_arbiter.sv
// Self-checking bench for the memory request arbiter: a transaction-level
// model checked every cycle, plus literal expectations per scenario.
module tb_t03_mem_request_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst, ack, next_hit, mem_read, mem_write;
  logic [31:0] pc, alu_addr, wdata_in;
  logic [3:0]  be_in;
  logic        read, write, freeze_pc, freeze_instr, cache_fill;
  logic        timeout_pulse, timeout_err, busy;
  logic [31:0] address, wdata;
  logic [3:0]  be;

  int checks = 0;
  int errors = 0;

  // Model: kind 0 none, 1 refill, 2 load, 3 store; age is 1 in the first bus cycle.
  int          kind = 0;
  int          age  = 0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wd   = '0;
  logic [3:0]  m_be   = '0;
  logic        m_err  = 1'b0;

  t03_mem_request_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ack          (ack),
    .next_hit     (next_hit),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .pc           (pc),
    .alu_addr     (alu_addr),
    .wdata_in     (wdata_in),
    .be_in        (be_in),
    .read         (read),
    .write        (write),
    .address      (address),
    .wdata        (wdata),
    .be           (be),
    .freeze_pc    (freeze_pc),
    .freeze_instr (freeze_instr),
    .cache_fill   (cache_fill),
    .timeout_pulse(timeout_pulse),
    .timeout_err  (timeout_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic mr, input logic mw,
                               input logic nh, input logic a,
                               input logic [31:0] p, input logic [31:0] aa,
                               input logic [31:0] wd, input logic [3:0] b);
    @(posedge clk);
    #1;
    rst = r; mem_read = mr; mem_write = mw; next_hit = nh; ack = a;
    pc = p; alu_addr = aa; wdata_in = wd; be_in = b;
    @(negedge clk);
  endtask

  // Every cycle: derive expected outputs from the transaction model, compare, then advance it.
  always @(negedge clk) begin
    int   nk;
    logic data_kind;
    logic e_fpc;
    data_kind = (kind == 2) || (kind == 3);
    nk = kind;
    if (rst) nk = 0;
    else if (kind == 0) begin
      if (mem_read)       nk = 2;
      else if (mem_write) nk = 3;
      else if (!next_hit) nk = 1;
    end else if (ack) nk = (data_kind && !next_hit) ? 1 : 0;
    else if (age == TO) nk = 0;
    e_fpc = (kind == 0) ? (nk != 0) : !(data_kind && ack && nk == 0);

    checkOutput("model_read",    32'(read),          32'(kind == 1 || kind == 2));
    checkOutput("model_write",   32'(write),         32'(kind == 3));
    checkOutput("model_busy",    32'(busy),          32'(kind != 0));
    checkOutput("model_finstr",  32'(freeze_instr),  32'(kind != 0));
    checkOutput("model_fpc",     32'(freeze_pc),     32'(e_fpc));
    checkOutput("model_fill",    32'(cache_fill),    32'(!rst && kind == 1 && ack));
    checkOutput("model_tpulse",  32'(timeout_pulse), 32'(!rst && kind != 0 && !ack && age == TO));
    checkOutput("model_terr",    32'(timeout_err),   32'(m_err));
    checkOutput("model_address", address,            m_addr);
    checkOutput("model_wdata",   wdata,              m_wd);
    checkOutput("model_be",      32'(be),            32'(m_be));

    if (rst) begin
      kind = 0; age = 0; m_addr = '0; m_wd = '0; m_be = '0; m_err = 1'b0;
    end else begin
      if (kind != 0 && !ack && age == TO) m_err = 1'b1;
      if (nk != 0 && nk != kind) begin
        m_addr = (nk == 1) ? pc : alu_addr;
        m_wd   = (nk == 3) ? wdata_in : 32'hFFFF_FFFF;
        m_be   = (nk == 3) ? be_in : 4'hF;
        age    = 1;
      end else if (nk != 0) begin
        age++;
      end
      kind = nk;
    end
  end

  // Directed scenarios with hand-computed literal expectations.
  initial begin
    rst = 1; mem_read = 0; mem_write = 0; next_hit = 1; ack = 0;
    pc = '0; alu_addr = '0; wdata_in = '0; be_in = '0;

    applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("rst_read", 32'(read), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_be",   32'(be), 0);
    checkOutput("rst_fpc",  32'(freeze_pc), 0);

    // Fetch miss, ack after 3 cycles.
    applyStimulus(0, 0, 0, 0, 0, 32'h100, 0, 0, 0);
    checkOutput("fetch_issue_read", 32'(read), 0);
    checkOutput("fetch_issue_fpc",  32'(freeze_pc), 1);
    applyStimulus(0, 0, 0, 1, 0, 32'h104, 0, 0, 0);
    checkOutput("fetch_c1_read", 32'(read), 1);
    checkOutput("fetch_c1_addr", address, 32'h100);
    checkOutput("fetch_c1_fill", 32'(cache_fill), 0);
    applyStimulus(0, 0, 0, 1, 0, 32'h108, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 32'h10C, 0, 0, 0);
    checkOutput("fetch_c3_fill", 32'(cache_fill), 1);
    checkOutput("fetch_c3_addr", address, 32'h100);
    applyStimulus(0, 0, 0, 1, 0, 32'h110, 0, 0, 0);
    checkOutput("fetch_done_busy", 32'(busy), 0);

    // Load then miss: refill chains directly after the load.
    applyStimulus(0, 1, 0, 0, 0, 32'h300, 32'h2000, 0, 0);
    checkOutput("load_issue_fpc", 32'(freeze_pc), 1);
    applyStimulus(0, 0, 0, 0, 1, 32'h300, 32'h2000, 0, 0);
    checkOutput("load_read", 32'(read), 1);
    checkOutput("load_addr", address, 32'h2000);
    checkOutput("load_fpc",  32'(freeze_pc), 1);
    applyStimulus(0, 0, 0, 1, 1, 32'h300, 32'h2000, 0, 0);
    checkOutput("chain_read", 32'(read), 1);
    checkOutput("chain_addr", address, 32'h300);
    checkOutput("chain_fill", 32'(cache_fill), 1);
    applyStimulus(0, 0, 0, 1, 0, 32'h304, 0, 0, 0);
    checkOutput("chain_done_busy", 32'(busy), 0);

    // Store with byte enables; inputs change during the wait.
    applyStimulus(0, 0, 1, 1, 0, 0, 32'h40, 32'hDEADBEEF, 4'b0011);
    applyStimulus(0, 0, 0, 1, 0, 0, 32'h80, 32'h12345678, 4'hF);
    checkOutput("store_write", 32'(write), 1);
    checkOutput("store_addr",  address, 32'h40);
    checkOutput("store_wdata", wdata, 32'hDEADBEEF);
    checkOutput("store_be",    32'(be), 32'h3);
    applyStimulus(0, 0, 0, 1, 0, 0, 32'h84, 32'h0, 4'h0);
    applyStimulus(0, 0, 0, 1, 1, 0, 32'h88, 32'h1, 4'h1);
    checkOutput("store_ack_wdata", wdata, 32'hDEADBEEF);
    checkOutput("store_ack_fpc",   32'(freeze_pc), 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);

    // Simultaneous read and write: the read wins.
    applyStimulus(0, 1, 1, 1, 0, 0, 32'h500, 32'h55, 4'h1);
    applyStimulus(0, 0, 0, 1, 1, 0, 32'h500, 32'h55, 4'h1);
    checkOutput("rw_read",  32'(read), 1);
    checkOutput("rw_write", 32'(write), 0);
    checkOutput("rw_be",    32'(be), 32'hF);
    checkOutput("rw_wdata", wdata, 32'hFFFFFFFF);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);

    // Ack in the timeout cycle: ack wins.
    applyStimulus(0, 0, 0, 0, 0, 32'h900, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 0, 32'h900, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 32'h900, 0, 0, 0);
    checkOutput("late_ack_tpulse", 32'(timeout_pulse), 0);
    checkOutput("late_ack_fill",   32'(cache_fill), 1);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("late_ack_terr", 32'(timeout_err), 0);

    // Timeout with ack held low.
    applyStimulus(0, 0, 0, 0, 0, 32'hA00, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 1, 0, 32'hA00, 0, 0, 0);
      checkOutput("to_wait_read", 32'(read), 1);
    end
    applyStimulus(0, 0, 0, 1, 0, 32'hA00, 0, 0, 0);
    checkOutput("to_c4_read",   32'(read), 1);
    checkOutput("to_c4_tpulse", 32'(timeout_pulse), 1);
    checkOutput("to_c4_terr",   32'(timeout_err), 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("to_after_busy", 32'(busy), 0);
    checkOutput("to_after_terr", 32'(timeout_err), 1);

    // Reset in the 2nd DWRITE cycle, then a normal request.
    applyStimulus(0, 0, 1, 1, 0, 0, 32'h600, 32'hAAAA5555, 4'hC);
    applyStimulus(0, 0, 0, 1, 0, 0, 32'h600, 32'hAAAA5555, 4'hC);
    checkOutput("rstmid_c1_write", 32'(write), 1);
    checkOutput("rstmid_terr",     32'(timeout_err), 1);
    applyStimulus(1, 0, 0, 1, 0, 0, 32'h600, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("rstmid_write", 32'(write), 0);
    checkOutput("rstmid_addr",  address, 0);
    checkOutput("rstmid_wdata", wdata, 0);
    checkOutput("rstmid_terr0", 32'(timeout_err), 0);
    applyStimulus(0, 1, 0, 1, 0, 0, 32'h700, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 0, 32'h700, 0, 0);
    checkOutput("post_rst_read", 32'(read), 1);
    checkOutput("post_rst_addr", address, 32'h700);

    // Reset during a refill ack: no fill strobe.
    applyStimulus(0, 0, 0, 0, 0, 32'hB00, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 1, 32'hB00, 0, 0, 0);
    checkOutput("rst_fill", 32'(cache_fill), 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("rst_fill_busy", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
